framebuffer_fetch_scheduler: RTL and testbench
==============================================

FRAMEBUFFER_FETCH_SCHEDULER -- requirements
Module: framebuffer_fetch_scheduler

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, 32, memory data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, 32, width of pixel index and byte address.
REQ-003 SHALL have parameter ID_WIDTH, 8, AXI ID width.
REQ-004 SHALL have parameter PIXEL_WIDTH, 16, pixel width in bits; STREAM_WIDTH/PIXEL_WIDTH SHALL be a power of two.
REQ-005 SHALL have parameter MAX_OUTSTANDING, 4, maximum in-flight reads (1..15).
REQ-006 SHALL have port aclk, input, 1, the single clock.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port s_fetch_axis_tvalid / _tready / _tlast, input/output/input, 1 each, upstream fetch handshake.
REQ-009 SHALL have port s_fetch_axis_tdest, input, ADDR_WIDTH, pixel index.
REQ-010 SHALL have port m_fetch_axis_tvalid / _tready / _tlast, output/input/output, 1 each, to serializer.
REQ-011 SHALL have port m_fetch_axis_tdest, output, ADDR_WIDTH, forwarded pixel index.
REQ-012 SHALL have port m_mem_axi_arvalid / _arready, output/input, 1 each, AXI read-address handshake.
REQ-013 SHALL have port m_mem_axi_araddr, output, ADDR_WIDTH, byte address of the line.
REQ-014 SHALL have port m_mem_axi_arid / _arlen / _arsize / _arburst, output, ID_WIDTH/8/3/2, constants 0 / 0 / log2(STREAM_WIDTH/8) / INCR.
REQ-015 SHALL have port m_mem_axi_rvalid / _rready / _rlast, input, 1 each, snooped R channel (driven by serializer).
REQ-016 SHALL have port cfg_base_addr, input, ADDR_WIDTH, framebuffer byte base address.
REQ-017 SHALL have port cfg_invalidate, input, 1, single-cycle pulse forgetting the last tag.

Function
REQ-018 SHALL compute tag = tdest >> log2(STREAM_WIDTH/PIXEL_WIDTH); araddr = cfg_base_addr + (tag << log2(STREAM_WIDTH/8)), truncated to ADDR_WIDTH.
REQ-019 SHALL implement states IDLE, ISSUE and FORWARD; only IDLE, or FORWARD while m_fetch_axis_tready is high, SHALL assert s_fetch_axis_tready (combinational).
REQ-020 SHALL, on fetch acceptance, register tdest/tlast; go to ISSUE if lastTagValid is 0 or tag != lastTag, otherwise go to FORWARD.
REQ-021 SHALL, in ISSUE, assert arvalid only when outstanding < MAX_OUTSTANDING, and hold arvalid and araddr stable until arready.
REQ-022 SHALL, on the AR handshake, set lastTag = tag and lastTagValid = 1, increment outstanding, and enter FORWARD the next cycle.
REQ-023 SHALL, in FORWARD, hold m_fetch_axis_tvalid high with stable data until tready; a simultaneous new acceptance goes directly to ISSUE/FORWARD (no bubble).
REQ-024 SHALL decrement outstanding on rvalid && rready && rlast; a simultaneous increment and decrement SHALL leave the count unchanged; the count SHALL never wrap.
REQ-025 SHALL clear lastTagValid after forwarding a beat with tlast=1, or on cfg_invalidate; when invalidate coincides with an AR handshake, invalidate SHALL win.
REQ-026 SHALL set minimum latency to 2 cycles for fetch-to-m_fetch on a tag hit, and 3 cycles (with arready high) on a miss.

Reset
REQ-027 SHALL, while resetn=0, asynchronously force state=IDLE, arvalid=0, m_fetch_axis_tvalid=0, tlast=0, outstanding=0, lastTagValid=0; araddr/tdest=0; a reset mid-transaction SHALL drop it without completion.

Configuration
REQ-028 SHALL, with FETCH_SCHEDULER_PERF_COUNTERS_EN defined, add 32-bit outputs perf_ar_count (AR handshakes) and perf_stall_cycles (ISSUE cycles blocked by the limit or arready), saturating and reset to 0; without the macro, the same ports SHALL exist tied to 0.

Structure
REQ-029 SHALL place the state enum and the AXI_BURST_INCR constant in shared package rasterix_fb_pkg; the outstanding counter SHALL be sub-module fb_outstanding_counter.

Verification
REQ-030 SHALL cover: base 0x1000, tdest 0,1,2,3 with STREAM 32 / PIXEL 16 -> two ARs at 0x1000 and 0x1004, four forwarded beats in order.
REQ-031 SHALL cover: MAX_OUTSTANDING=2 with no R beats and tdest 0,2,4 -> exactly two ARs, the third held with arvalid=0 until one rlast beat.
REQ-032 SHALL cover: arready low for 5 cycles -> araddr stable, arvalid held, s_fetch_axis_tready low.
REQ-033 SHALL cover: tdest 6 with tlast=1, then tdest 7 -> a second AR for tag 3 is issued.
REQ-034 SHALL cover: AR handshake and rlast in the same cycle at outstanding=1 -> outstanding stays 1.
REQ-035 SHALL cover: resetn low during ISSUE -> arvalid=0 and m_fetch_axis_tvalid=0 in the same cycle; the first post-reset fetch issues an AR.

Source files
------------

// File: rtl/rasterix_fb_pkg.sv
// Shared types and constants for the framebuffer fetch path.
package rasterix_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FORWARD
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Wide enough for MAX_OUTSTANDING up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/fb_outstanding_counter.sv
// In-flight AXI read counter; a simultaneous increment and decrement cancel,
// and the count saturates at both ends.
module fb_outstanding_counter
  import rasterix_fb_pkg::*;
(
  input  logic             aclk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && !dec && (count != '1)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/framebuffer_fetch_scheduler.sv
// Turns pixel fetch requests into single-beat AXI line reads, skipping the read
// when the line was already requested. Optional FETCH_SCHEDULER_PERF_COUNTERS_EN.
module framebuffer_fetch_scheduler
  import rasterix_fb_pkg::*;
#(
  parameter int STREAM_WIDTH    = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int PIXEL_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s_fetch_axis_tvalid,
  output logic                  s_fetch_axis_tready,
  input  logic                  s_fetch_axis_tlast,
  input  logic [ADDR_WIDTH-1:0] s_fetch_axis_tdest,
  output logic                  m_fetch_axis_tvalid,
  input  logic                  m_fetch_axis_tready,
  output logic                  m_fetch_axis_tlast,
  output logic [ADDR_WIDTH-1:0] m_fetch_axis_tdest,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  input  logic                  m_mem_axi_rvalid,
  input  logic                  m_mem_axi_rready,
  input  logic                  m_mem_axi_rlast,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                  cfg_invalidate,
  output logic [31:0]           perf_ar_count,
  output logic [31:0]           perf_stall_cycles
);

  localparam int PIX_SHIFT  = $clog2(STREAM_WIDTH / PIXEL_WIDTH);
  localparam int BYTE_SHIFT = $clog2(STREAM_WIDTH / 8);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  fetch_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] tag_in, addr_in;
  logic [ADDR_WIDTH-1:0] tag_q, last_tag;
  logic                  last_tag_valid, tag_valid_eff, hit;
  logic                  accept, ar_fire, fwd_done, r_done;
  logic [CNT_W-1:0]      outstanding;

  assign tag_in  = s_fetch_axis_tdest >> PIX_SHIFT;
  assign addr_in = cfg_base_addr + (tag_in << BYTE_SHIFT);
  assign r_done  = m_mem_axi_rvalid && m_mem_axi_rready && m_mem_axi_rlast;

  assign m_mem_axi_arid    = '0;
  assign m_mem_axi_arlen   = 8'd0;
  assign m_mem_axi_arsize  = 3'(BYTE_SHIFT);
  assign m_mem_axi_arburst = AXI_BURST_INCR;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    m_mem_axi_arvalid   = 1'b0;
    m_fetch_axis_tvalid = 1'b0;
    s_fetch_axis_tready = 1'b0;
    ar_fire             = 1'b0;
    fwd_done            = 1'b0;
    accept              = 1'b0;
    tag_valid_eff       = 1'b0;
    hit                 = 1'b0;
    case (state_q)
      ST_IDLE: s_fetch_axis_tready = 1'b1;
      ST_ISSUE: begin
        m_mem_axi_arvalid = (outstanding < MAX_CNT);
        ar_fire           = m_mem_axi_arvalid && m_mem_axi_arready;
        if (ar_fire) state_d = ST_FORWARD;
      end
      ST_FORWARD: begin
        m_fetch_axis_tvalid = 1'b1;
        fwd_done            = m_fetch_axis_tready;
        s_fetch_axis_tready = m_fetch_axis_tready;
        if (fwd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A tlast beat leaving this cycle must already hide the tag from a back-to-back request.
    tag_valid_eff = last_tag_valid && !cfg_invalidate && !(fwd_done && m_fetch_axis_tlast);
    hit           = tag_valid_eff && (tag_in == last_tag);
    accept        = s_fetch_axis_tvalid && s_fetch_axis_tready;
    if (accept) state_d = hit ? ST_FORWARD : ST_ISSUE;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_fetch_axis_tdest <= '0;
      m_fetch_axis_tlast <= 1'b0;
      m_mem_axi_araddr   <= '0;
      tag_q              <= '0;
    end else if (accept) begin
      m_fetch_axis_tdest <= s_fetch_axis_tdest;
      m_fetch_axis_tlast <= s_fetch_axis_tlast;
      m_mem_axi_araddr   <= addr_in;
      tag_q              <= tag_in;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      last_tag       <= '0;
      last_tag_valid <= 1'b0;
    end else begin
      if (ar_fire) last_tag <= tag_q;
      if (cfg_invalidate || (fwd_done && m_fetch_axis_tlast)) last_tag_valid <= 1'b0;
      else if (ar_fire)                                       last_tag_valid <= 1'b1;
    end
  end

  fb_outstanding_counter u_outstanding (
    .aclk   (aclk),
    .resetn (resetn),
    .inc    (ar_fire),
    .dec    (r_done),
    .count  (outstanding)
  );

`ifdef FETCH_SCHEDULER_PERF_COUNTERS_EN
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      perf_ar_count     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (ar_fire && (perf_ar_count != '1))
        perf_ar_count <= perf_ar_count + 1'b1;
      if ((state_q == ST_ISSUE) && !ar_fire && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`else
  assign perf_ar_count     = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_framebuffer_fetch_scheduler.sv
// Directed bench for framebuffer_fetch_scheduler (MAX_OUTSTANDING=2, base 0x1000).
module tb_framebuffer_fetch_scheduler;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdest = '0;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdest;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic [31:0] base = 32'h1000;
  logic        inval = 1'b0;
  logic [31:0] perf_ar, perf_stall;

  int checks = 0;
  int failures = 0;
  int ar_cnt = 0;
  int fwd_cnt = 0;
  logic [31:0] ar_log [0:63];
  logic [31:0] fwd_dest [0:63];
  logic        fwd_last [0:63];

  always #5 aclk = ~aclk;

  framebuffer_fetch_scheduler #(
    .STREAM_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .PIXEL_WIDTH(16), .MAX_OUTSTANDING(2)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s_fetch_axis_tvalid(s_tvalid), .s_fetch_axis_tready(s_tready),
    .s_fetch_axis_tlast(s_tlast), .s_fetch_axis_tdest(s_tdest),
    .m_fetch_axis_tvalid(m_tvalid), .m_fetch_axis_tready(m_tready),
    .m_fetch_axis_tlast(m_tlast), .m_fetch_axis_tdest(m_tdest),
    .m_mem_axi_arvalid(arvalid), .m_mem_axi_arready(arready),
    .m_mem_axi_araddr(araddr), .m_mem_axi_arid(arid), .m_mem_axi_arlen(arlen),
    .m_mem_axi_arsize(arsize), .m_mem_axi_arburst(arburst),
    .m_mem_axi_rvalid(rvalid), .m_mem_axi_rready(rready), .m_mem_axi_rlast(rlast),
    .cfg_base_addr(base), .cfg_invalidate(inval),
    .perf_ar_count(perf_ar), .perf_stall_cycles(perf_stall)
  );

  always @(posedge aclk) begin
    if (resetn) begin
      if (arvalid && arready) begin
        if (ar_cnt < 64) ar_log[ar_cnt] = araddr;
        ar_cnt++;
      end
      if (m_tvalid && m_tready) begin
        if (fwd_cnt < 64) begin
          fwd_dest[fwd_cnt] = m_tdest;
          fwd_last[fwd_cnt] = m_tlast;
        end
        fwd_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic fetch(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1; s_tdest = d; s_tlast = l;
    while (!s_tready && n < 200) begin @(posedge aclk); #1; n++; end
    if (!s_tready) begin
      checks++; failures++;
      $display("FAIL fetch_accept tdest=%0d tready=%b required 1", d, s_tready);
      s_tvalid = 1'b0;
    end else begin
      @(posedge aclk); #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic rbeat();
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    @(posedge aclk); #1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
  endtask

  task automatic clean();
    inval = 1'b1; @(posedge aclk); #1; inval = 1'b0;
    rbeat(); rbeat();
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if (arvalid !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids arvalid=%b tvalid=%b tlast=%b required 0", arvalid, m_tvalid, m_tlast);
    end
    checks++;
    if (araddr !== 32'h0 || m_tdest !== 32'h0 || s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_data araddr=%h tdest=%h s_tready=%b required 0/0/1", araddr, m_tdest, s_tready);
    end
    checks++;
    if (arid !== 8'd0 || arlen !== 8'd0 || arsize !== 3'd2 || arburst !== 2'b01) begin
      failures++;
      $display("FAIL ar_consts id=%0d len=%0d size=%0d burst=%0d required 0/0/2/1", arid, arlen, arsize, arburst);
    end
    checks++;
    if (perf_ar !== 32'd0 || perf_stall !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf ar=%0d stall=%0d required 0", perf_ar, perf_stall);
    end
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int a0, f0;
    clean();
    a0 = ar_cnt; f0 = fwd_cnt;
    fetch(0, 0); fetch(1, 0); fetch(2, 0); fetch(3, 0);
    idle(4);
    checks++;
    if (ar_cnt - a0 != 2) begin
      failures++; $display("FAIL basic_ar_count got=%0d required 2", ar_cnt - a0);
    end else begin
      checks++;
      if (ar_log[a0] !== 32'h1000 || ar_log[a0+1] !== 32'h1004) begin
        failures++;
        $display("FAIL basic_araddr got=%h,%h required 1000,1004", ar_log[a0], ar_log[a0+1]);
      end
    end
    checks++;
    if (fwd_cnt - f0 != 4) begin
      failures++; $display("FAIL basic_fwd_count got=%0d required 4", fwd_cnt - f0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fwd_dest[f0+i] !== 32'(i)) begin
          failures++; $display("FAIL basic_fwd_order idx=%0d got=%0d required %0d", i, fwd_dest[f0+i], i);
        end
      end
    end
    rbeat(); rbeat();
  endtask

  task automatic test_latency();
    clean();
    s_tvalid = 1'b1; s_tdest = 32'd8; s_tlast = 1'b0;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || m_tvalid !== 1'b0 || araddr !== 32'h1010) begin
      failures++;
      $display("FAIL miss_cycle1 arvalid=%b tvalid=%b araddr=%h required 1/0/1010", arvalid, m_tvalid, araddr);
    end
    @(posedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdest !== 32'd8) begin
      failures++; $display("FAIL miss_cycle2 tvalid=%b tdest=%0d required 1/8", m_tvalid, m_tdest);
    end
    s_tvalid = 1'b1; s_tdest = 32'd9;
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdest !== 32'd9 || arvalid !== 1'b0) begin
      failures++;
      $display("FAIL hit_no_bubble tvalid=%b tdest=%0d arvalid=%b required 1/9/0", m_tvalid, m_tdest, arvalid);
    end
    idle(2);
    rbeat(); rbeat();
  endtask

  task automatic test_limit();
    int a0;
    clean();
    a0 = ar_cnt;
    fetch(0, 0); fetch(2, 0); fetch(4, 0);
    idle(5);
    checks++;
    if (ar_cnt - a0 != 2 || arvalid !== 1'b0 || s_tready !== 1'b0) begin
      failures++;
      $display("FAIL limit_hold ars=%0d arvalid=%b s_tready=%b required 2/0/0", ar_cnt - a0, arvalid, s_tready);
    end
    rbeat();
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1008) begin
      failures++; $display("FAIL limit_release arvalid=%b araddr=%h required 1/1008", arvalid, araddr);
    end
    idle(3);
    checks++;
    if (ar_cnt - a0 != 3) begin
      failures++; $display("FAIL limit_total ars=%0d required 3", ar_cnt - a0);
    end
    rbeat(); rbeat();
  endtask

  task automatic test_arready_stall();
    clean();
    arready = 1'b0;
    fetch(10, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h1014 || s_tready !== 1'b0) begin
        failures++;
        $display("FAIL arready_stall cyc=%0d arvalid=%b araddr=%h s_tready=%b required 1/1014/0", i, arvalid, araddr, s_tready);
      end
      idle(1);
    end
    arready = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdest !== 32'd10) begin
      failures++; $display("FAIL stall_forward tvalid=%b tdest=%0d required 1/10", m_tvalid, m_tdest);
    end
    idle(2);
    rbeat(); rbeat();
  endtask

  task automatic test_tlast();
    int a0, f0;
    clean();
    a0 = ar_cnt; f0 = fwd_cnt;
    fetch(6, 1); fetch(7, 0);
    idle(4);
    checks++;
    if (ar_cnt - a0 != 2) begin
      failures++; $display("FAIL tlast_reissue ars=%0d required 2", ar_cnt - a0);
    end else begin
      checks++;
      if (ar_log[a0+1] !== 32'h100C) begin
        failures++; $display("FAIL tlast_addr got=%h required 100c", ar_log[a0+1]);
      end
    end
    checks++;
    if (fwd_cnt - f0 != 2 || fwd_last[f0] !== 1'b1 || fwd_dest[f0+1] !== 32'd7) begin
      failures++;
      $display("FAIL tlast_fwd n=%0d last0=%b dest1=%0d required 2/1/7", fwd_cnt - f0, fwd_last[f0], fwd_dest[f0+1]);
    end
    rbeat(); rbeat();
  endtask

  task automatic test_inc_dec();
    clean();
    fetch(20, 0);
    fetch(22, 0);
    checks++;
    if (arvalid !== 1'b1) begin
      failures++; $display("FAIL incdec_pre arvalid=%b required 1", arvalid);
    end
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    @(posedge aclk); #1;
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    fetch(24, 0);
    checks++;
    if (arvalid !== 1'b1) begin
      failures++; $display("FAIL incdec_count_one arvalid=%b required 1", arvalid);
    end
    fetch(26, 0);
    idle(3);
    checks++;
    if (arvalid !== 1'b0) begin
      failures++; $display("FAIL incdec_count_two arvalid=%b required 0", arvalid);
    end
    rbeat();
    checks++;
    if (arvalid !== 1'b1) begin
      failures++; $display("FAIL incdec_release arvalid=%b required 1", arvalid);
    end
    idle(3);
    rbeat(); rbeat();
  endtask

  task automatic test_reset_mid();
    int a0, f0;
    clean();
    fetch(30, 0);
    idle(3);
    arready = 1'b0;
    fetch(32, 0);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || m_tvalid !== 1'b0 || araddr !== 32'h0) begin
      failures++;
      $display("FAIL midreset arvalid=%b tvalid=%b araddr=%h required 0/0/0", arvalid, m_tvalid, araddr);
    end
    @(posedge aclk); #1;
    resetn = 1'b1; arready = 1'b1;
    idle(1);
    a0 = ar_cnt; f0 = fwd_cnt;
    fetch(30, 0);
    idle(3);
    checks++;
    if (ar_cnt - a0 != 1) begin
      failures++; $display("FAIL postreset_ar ars=%0d required 1", ar_cnt - a0);
    end else begin
      checks++;
      if (ar_log[a0] !== 32'h103C || fwd_dest[f0] !== 32'd30) begin
        failures++; $display("FAIL postreset_data araddr=%h dest=%0d required 103c/30", ar_log[a0], fwd_dest[f0]);
      end
    end
    checks++;
`ifdef FETCH_SCHEDULER_PERF_COUNTERS_EN
    if (perf_ar !== 32'd1) begin
      failures++; $display("FAIL perf_ar got=%0d required 1", perf_ar);
    end
`else
    if (perf_ar !== 32'd0 || perf_stall !== 32'd0) begin
      failures++; $display("FAIL perf_tied ar=%0d stall=%0d required 0", perf_ar, perf_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_limit();
    test_arready_stall();
    test_tlast();
    test_inc_dec();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
